board_debug_ctrl: RTL and testbench
===================================

BOARD_DEBUG_CTRL -- requirements
Module: board_debug_ctrl

Interface
REQ-001 The block SHALL have the parameter DEBOUNCE_CYCLES, default 50000: number of consecutive stable cycles required before a button level is accepted.
REQ-002 The block SHALL have the parameter REFRESH_CYCLES, default 100000: clock cycles each display digit stays lit.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port step_btn, input, 1: raw, asynchronous, bouncing push-button level.
REQ-006 Port sel_pc, input, 1: 1 = display the processor PC, 0 = display the selected register.
REQ-007 Port half_sel, input, 1: 1 = display bits [31:16], 0 = display bits [15:0].
REQ-008 Port reg_sw, input, 5: register index selected on the board switches.
REQ-009 Port pc_in, input, 32: PC value consumed from the processor's syn_pc output.
REQ-010 Port reg_in, input, 32: register value consumed from the processor's syn_reg_out output.
REQ-011 Port syn_reg_dst, output, 5: register index driven to the processor.
REQ-012 Port step, output, 1: one-cycle pulse per accepted button press.
REQ-013 Port an, output, 4: digit anodes, active-low, one-hot-low while scanning.
REQ-014 Port seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-015 Port dp, output, 1: decimal point, active-low.

Function
REQ-016 step_btn SHALL pass through a two-flop synchronizer before any other use.
REQ-017 Debounce: a counter SHALL increment while the synchronized level differs from the stable level, and SHALL clear when the levels match.
REQ-018 When the debounce counter reaches DEBOUNCE_CYCLES-1 with the levels still differing, the stable level SHALL take the synchronized value and the counter SHALL clear.
REQ-019 step SHALL be 1 for exactly the one cycle after the stable level rises 0->1; the falling edge and a held button SHALL produce no pulse.
REQ-020 Any mismatch shorter than DEBOUNCE_CYCLES cycles SHALL leave the stable level and step unchanged.
REQ-021 syn_reg_dst SHALL be reg_sw registered, giving a 1-cycle latency.
REQ-022 The refresh counter SHALL count 0..REFRESH_CYCLES-1 and then wrap to 0.
REQ-023 On each refresh wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-024 an[i] SHALL be 0 only when the digit index equals i; digit 0 is the least-significant nibble.
REQ-025 A 16-bit snapshot SHALL load the selected half of the selected source (sel_pc, half_sel) on the cycle the digit index wraps 3->0, and once after reset. Input changes mid-scan SHALL NOT alter the digits shown until the next wrap.
REQ-026 seg SHALL show the hex glyph of snapshot nibble [4*idx+3:4*idx], with 0-9 and A,b,C,d,E,F in standard active-low encoding (0 -> 7'b1000000, F -> 7'b0001110).
REQ-027 dp SHALL be 0 on digit 0 when half_sel=1, marking the upper half; otherwise dp SHALL be 1.
REQ-028 an, seg and dp SHALL be registered outputs, consistent within the same cycle.

Reset
REQ-029 While rst=1, the block SHALL hold: step=0, syn_reg_dst=0, an=4'b1111, seg=7'h7F, dp=1, stable level 0, all counters 0, digit index 0, snapshot 0.
REQ-030 rst asserted mid-scan or mid-debounce SHALL abandon the operation, with no step pulse.
REQ-031 On the first cycle after rst, the snapshot SHALL load and scanning SHALL start at digit 0.

Verification (DEBOUNCE_CYCLES=4, REFRESH_CYCLES=3)
REQ-032 Bench: step_btn held 1 for 20 cycles -> exactly one step pulse, 2+4 cycles after the rise, plus 1 cycle for the output register.
REQ-033 Bench: step_btn toggled 1/0 every 2 cycles for 20 cycles, then held 0 -> step never asserts.
REQ-034 Bench: sel_pc=1, half_sel=0, pc_in=32'h0000_1A2F -> an cycles 1110, 1101, 1011, 0111 with 3 cycles each; seg shows F, 2, A, 1.
REQ-035 Bench: sel_pc=0, half_sel=1, reg_in=32'hDEAD_0000 -> digits D, A, E, D; dp=0 only on digit 0.
REQ-036 Bench: reg_in changed from 32'h1111 to 32'h2222 while digit 1 is lit -> digits 2-3 still show 1; all digits show 2 after the 3->0 wrap.
REQ-037 Bench: reg_sw=5'd17, then rst pulsed during a debounce count -> syn_reg_dst=0 with all outputs at reset values; after release, syn_reg_dst=17 one cycle later and no step pulse.

Source files
------------

// File: rtl/board_debug_ctrl.sv
// Board-level debug controller: debounced single-step button, registered register
// select, and a four-digit multiplexed hex display of the PC or a register half.
module board_debug_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REFRESH_CYCLES  = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_btn,
    input  logic        sel_pc,
    input  logic        half_sel,
    input  logic [4:0]  reg_sw,
    input  logic [31:0] pc_in,
    input  logic [31:0] reg_in,
    output logic [4:0]  syn_reg_dst,
    output logic        step,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned REF_W = $clog2(REFRESH_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             stable_prev_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic             step_q, step_d;
    logic [4:0]       dst_q;
    logic [REF_W-1:0] ref_q, ref_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      snap_q, snap_d;
    logic             load_pending_q;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [31:0]      src;
    logic [15:0]      src_half;

    assign src      = sel_pc ? pc_in : reg_in;
    assign src_half = half_sel ? src[31:16] : src[15:0];

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync2_q != stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                stable_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        step_d = stable_q & ~stable_prev_q;

        ref_d  = ref_q;
        idx_d  = idx_q;
        snap_d = snap_q;
        // The first cycle after reset only captures the snapshot, so digit 0
        // gets its full refresh period like every other digit.
        if (load_pending_q) begin
            snap_d = src_half;
        end else if (ref_q == REF_LAST) begin
            ref_d = '0;
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                snap_d = src_half;
            end
        end else begin
            ref_d = ref_q + 1'b1;
        end

        // Outputs are decoded from next-state so anode, glyph and dp stay aligned.
        an_d  = ~(4'b0001 << idx_d);
        seg_d = hex_glyph(snap_d[{idx_d, 2'b00} +: 4]);
        dp_d  = ~((idx_d == 2'd0) & half_sel);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            stable_q       <= 1'b0;
            stable_prev_q  <= 1'b0;
            db_cnt_q       <= '0;
            step_q         <= 1'b0;
            dst_q          <= '0;
            ref_q          <= '0;
            idx_q          <= '0;
            snap_q         <= '0;
            load_pending_q <= 1'b1;
            an_q           <= 4'b1111;
            seg_q          <= 7'h7F;
            dp_q           <= 1'b1;
        end else begin
            sync1_q        <= step_btn;
            sync2_q        <= sync1_q;
            stable_q       <= stable_d;
            stable_prev_q  <= stable_q;
            db_cnt_q       <= db_cnt_d;
            step_q         <= step_d;
            dst_q          <= reg_sw;
            ref_q          <= ref_d;
            idx_q          <= idx_d;
            snap_q         <= snap_d;
            load_pending_q <= 1'b0;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
        end
    end

    assign syn_reg_dst = dst_q;
    assign step        = step_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;

endmodule

// File: tb/tb_board_debug_ctrl.sv
// Self-checking bench for board_debug_ctrl: a cycle-level behavioural model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_board_debug_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_btn = 1'b0;
    logic        sel_pc = 1'b1;
    logic        half_sel = 1'b0;
    logic [4:0]  reg_sw = 5'd0;
    logic [31:0] pc_in = 32'h0000_1A2F;
    logic [31:0] reg_in = 32'h0;
    logic [4:0]  syn_reg_dst;
    logic        step;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_cmp = 0;
    int n_bad = 0;

    board_debug_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REFRESH_CYCLES (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .step_btn   (step_btn),
        .sel_pc     (sel_pc),
        .half_sel   (half_sel),
        .reg_sw     (reg_sw),
        .pc_in      (pc_in),
        .reg_in     (reg_in),
        .syn_reg_dst(syn_reg_dst),
        .step       (step),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: k counts cycles since reset release; each digit owns three
    // cycles, a full scan is twelve, and the snapshot is taken at each scan start.
    // The button is accepted when the synchronized samples (two cycles old) have
    // disagreed with the accepted level for four consecutive cycles.
    int          m_k = 0;
    logic [5:0]  m_hist = '0;
    logic        m_stable = 1'b0;
    logic        m_rose = 1'b0;
    logic [15:0] m_snap = '0;
    logic        m_valid = 1'b0;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_step;
    logic [4:0]  e_dst;

    always @(posedge clk) begin
        int digit;
        logic [31:0] s;
        if (rst) begin
            m_k = 0; m_hist = '0; m_stable = 1'b0; m_rose = 1'b0; m_snap = '0;
            e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1; e_step = 1'b0; e_dst = 5'd0;
        end else begin
            e_dst  = reg_sw;
            e_step = m_rose;
            m_hist = {m_hist[4:0], step_btn};
            m_rose = 1'b0;
            if (m_stable ? (m_hist[5:2] == 4'b0000) : (m_hist[5:2] == 4'b1111)) begin
                m_rose   = ~m_stable;
                m_stable = ~m_stable;
            end
            digit = (m_k / 3) % 4;
            if (m_k % 12 == 0) begin
                s = sel_pc ? pc_in : reg_in;
                m_snap = half_sel ? s[31:16] : s[15:0];
            end
            e_an  = ~(4'b0001 << digit);
            e_seg = glyph_tab[m_snap[4*digit +: 4]];
            e_dp  = !(digit == 0 && half_sel);
            m_k++;
        end
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_an", {28'd0, an}, {28'd0, e_an});
            check("model_seg", {25'd0, seg}, {25'd0, e_seg});
            check("model_dp", {31'd0, dp}, {31'd0, e_dp});
            check("model_step", {31'd0, step}, {31'd0, e_step});
            check("model_dst", {27'd0, syn_reg_dst}, {27'd0, e_dst});
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, {28'd0, an}, 32'hF);
        check({tag, "_seg"}, {25'd0, seg}, 32'h7F);
        check({tag, "_dp"}, {31'd0, dp}, 32'h1);
        check({tag, "_step"}, {31'd0, step}, 32'h0);
        check({tag, "_dst"}, {27'd0, syn_reg_dst}, 32'h0);
    endtask

    logic [3:0] an_lit   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] pc_seg   [4] = '{7'b0001110, 7'b0100100, 7'b0001000, 7'b1111001};
    logic [6:0] dead_seg [4] = '{7'b0100001, 7'b0001000, 7'b0000110, 7'b0100001};
    logic [6:0] one_glyph = 7'b1111001;
    logic [6:0] two_glyph = 7'b0100100;

    initial begin
        int pulses;
        int pulse_at;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // PC low half 0x1A2F scanned from digit 0 right after release
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("pc_an", {28'd0, an}, {28'd0, an_lit[k/3]});
            check("pc_seg", {25'd0, seg}, {25'd0, pc_seg[k/3]});
            check("pc_dp", {31'd0, dp}, 32'h1);
        end

        // Button held: one pulse, six cycles after the first sampled edge
        pulses = 0; pulse_at = -1;
        step_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (step) begin pulses++; pulse_at = i; end
        end
        check("held_pulses", pulses, 1);
        check("held_pulse_cycle", pulse_at, 6);

        pulses = 0;
        step_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (step) pulses++;
        end
        check("release_pulses", pulses, 0);

        // Bouncing input: two-cycle runs never reach the debounce threshold
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step_btn = ((i / 2) % 2 == 0);
            @(negedge clk);
            if (step) pulses++;
        end
        step_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (step) pulses++;
        end
        check("bounce_pulses", pulses, 0);

        // Register upper half 0xDEAD with the decimal point on digit 0
        sel_pc = 1'b0; half_sel = 1'b1; reg_in = 32'hDEAD_0000;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("dead_an", {28'd0, an}, {28'd0, an_lit[k/3]});
            check("dead_seg", {25'd0, seg}, {25'd0, dead_seg[k/3]});
            check("dead_dp", {31'd0, dp}, (k / 3 == 0) ? 32'h0 : 32'h1);
        end

        // Snapshot holds 0x1111 across a mid-scan change until the next scan
        half_sel = 1'b0; reg_in = 32'h0000_1111;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (k == 3) reg_in = 32'h0000_2222;
            check("snap_seg", {25'd0, seg}, {25'd0, (k < 12) ? one_glyph : two_glyph});
        end

        // Reset mid-debounce: outputs return to reset values, no pulse afterwards
        reg_sw = 5'd17;
        repeat (2) @(negedge clk);
        check("dst_before_rst", {27'd0, syn_reg_dst}, 32'd17);
        step_btn = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1; step_btn = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("dst_after_rst", {27'd0, syn_reg_dst}, 32'd17);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (step) pulses++;
        end
        check("post_rst_pulses", pulses, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
